w_writeback: RTL and testbench
==============================

W_WRITEBACK -- requirements
Module: w_writeback

Interface
REQ-001 The block SHALL expose these ports: Clk  input  1  single clock, all state updates on the rising edge.
REQ-002 The block SHALL expose these ports: Rst  input  1  reset, asynchronous, active-low (Rst=0 resets).
REQ-003 The block SHALL expose these ports: Valid  input  1  W stage holds a real, retiring instruction.
REQ-004 The block SHALL expose these ports: WbSel  input  3  writeback source, 0=Y, 1=extended load data, 2=PC+8, 3=HILO, 4=set-less-than from ACmpB.
REQ-005 The block SHALL expose these ports: WbAddr  input  5  destination GPR index.
REQ-006 The block SHALL expose these ports: LdType  input  3  load extension, 0=word, 1=lbu, 2=lb, 3=lhu, 4=lh.
REQ-007 The block SHALL expose these ports: PC, DR, Y, HILO  input  32 each  W-stage PC, raw memory word, ALU result/address, HI/LO value.
REQ-008 The block SHALL expose these ports: ACmpB  input  2  compare of A vs B, 2'b01 = A<B, 2'b00 = equal, 2'b10 = A>B.
REQ-009 The block SHALL expose these ports: RAddr1, RAddr2  input  5  D-stage read indices.
REQ-010 The block SHALL expose these ports: RData1, RData2  output  32  read data.
REQ-011 The block SHALL expose these ports: WbData  output  32  selected writeback value, combinational, for forwarding.
REQ-012 The block SHALL expose these ports: WbWe  output  1  effective write enable, Valid and WbAddr!=0.
REQ-013 The block SHALL expose these ports: RetireCnt  output  32  retired-instruction counter.
REQ-014 The block SHALL expose these ports: LastPC  output  32  PC of the most recently retired instruction.

Function
REQ-015 The block SHALL hold 31 writable 32-bit GPRs (1..31), with GPR0 reading 0 at all times.
REQ-016 WbData SHALL be selected by WbSel: 0 gives Y, 1 gives the extended load data, 2 gives PC+8 (mod 2^32), 3 gives HILO, 4 gives {31'b0, ACmpB==2'b01}, and 5..7 give 0.
REQ-017 Load extension SHALL use offsets Y[1:0] (byte) and Y[1] (half): the byte is DR[8*Y[1:0]+7 -: 8] and the half is DR[16*Y[1]+15 -: 16]. lbu/lhu SHALL zero-extend, lb/lh SHALL sign-extend, and word passes DR. LdType 5..7 SHALL give DR.
REQ-018 On a rising Clk with WbWe=1, GPR[WbAddr] SHALL take WbData; a write to index 0 SHALL be discarded.
REQ-019 Reads SHALL be combinational: RDataN = 0 if RAddrN==0; else WbData if WbWe and RAddrN==WbAddr (same-cycle bypass); else GPR[RAddrN].
REQ-020 Both read ports SHALL be independent, and the same address on both ports SHALL return identical data.
REQ-021 On a rising Clk with Valid=1, RetireCnt SHALL increment by 1 (wrapping 0xFFFFFFFF to 0) and LastPC SHALL take PC, regardless of WbAddr.
REQ-022 With Valid=0, no GPR, RetireCnt or LastPC SHALL change, and WbWe SHALL be 0.
REQ-023 Write latency SHALL be 1 cycle (visible from GPR storage the next cycle) and visible in the same cycle via the bypass.

Reset
REQ-024 Rst=0 SHALL immediately and asynchronously clear GPR1..31, RetireCnt and LastPC to 0, independent of Clk.
REQ-025 While Rst=0, no write or count SHALL occur; the first update SHALL be on the first rising Clk after Rst returns to 1.
REQ-026 Rst asserted mid-write cycle SHALL discard that write.
REQ-027 During reset, combinational outputs (WbData, WbWe, RData) SHALL still follow the inputs, with the GPR contents reading 0.

Verification
REQ-028 The bench SHALL cover: Rst=0 pulse mid-cycle after several writes -> all RData 0, RetireCnt=0, LastPC=0 before the next edge.
REQ-029 The bench SHALL cover: Valid=1, WbSel=0, WbAddr=5, Y=0x12345678, RAddr1=5 same cycle -> RData1=0x12345678 via bypass; the next cycle with Valid=0 -> RData1 still 0x12345678.
REQ-030 The bench SHALL cover: WbSel=1, DR=0x80FF7F01, Y[1:0]=3, lb -> 0xFFFFFF80; lbu -> 0x00000080; Y[1]=0, lh -> 0x00007F01; Y[1]=1, lh -> 0xFFFF80FF.
REQ-031 The bench SHALL cover: Valid=1, WbAddr=0, WbSel=2, PC=0x00003000 -> WbData=0x00003008, WbWe=0, GPR0 reads 0, RetireCnt increments, LastPC=0x00003000.
REQ-032 The bench SHALL cover: WbSel=4 with ACmpB=01 -> WbData=1, with ACmpB=10 -> 0; WbSel=3, HILO=0xDEADBEEF -> 0xDEADBEEF.
REQ-033 The bench SHALL cover: RetireCnt forced near wrap (0xFFFFFFFF reached by retiring) plus one retire -> 0x00000000.

Source files
------------

// File: rtl/w_writeback_if.sv
// Writeback-stage bundle: retiring-instruction inputs, register-file read
// ports and the architectural status outputs of the W stage.
//
// Valid marks a real, retiring instruction in W. There is no back-pressure:
// whenever Valid is high on a rising clock the instruction retires.
interface w_writeback_if;
    logic        Valid;
    logic [2:0]  WbSel;
    logic [4:0]  WbAddr;
    logic [2:0]  LdType;
    logic [31:0] PC;
    logic [31:0] DR;
    logic [31:0] Y;
    logic [31:0] HILO;
    logic [1:0]  ACmpB;
    logic [4:0]  RAddr1;
    logic [4:0]  RAddr2;
    logic [31:0] RData1;
    logic [31:0] RData2;
    logic [31:0] WbData;
    logic        WbWe;
    logic [31:0] RetireCnt;
    logic [31:0] LastPC;

    // Pipeline side: drives the retiring instruction and read indices.
    modport master (
        output Valid, WbSel, WbAddr, LdType, PC, DR, Y, HILO, ACmpB,
        output RAddr1, RAddr2,
        input  RData1, RData2, WbData, WbWe, RetireCnt, LastPC
    );

    // Writeback block side.
    modport slave (
        input  Valid, WbSel, WbAddr, LdType, PC, DR, Y, HILO, ACmpB,
        input  RAddr1, RAddr2,
        output RData1, RData2, WbData, WbWe, RetireCnt, LastPC
    );
endinterface

// File: rtl/w_writeback.sv
// W stage: selects the writeback value, extends load data, owns the
// 31-entry GPR file (GPR0 is hard zero) with same-cycle read bypass, and
// keeps the retired-instruction counter and last retired PC.
module w_writeback (
    input logic         Clk,
    input logic         Rst,
    w_writeback_if.slave wb
);

    logic [31:0] gpr_q [1:31];
    logic [31:0] gpr_d [1:31];
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] last_pc_q, last_pc_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data;
    logic        wb_we;

    // Load extension: pick the addressed byte/half of the memory word.
    always_comb begin
        ld_byte = wb.DR[{wb.Y[1:0], 3'b000} +: 8];
        ld_half = wb.DR[{wb.Y[1], 4'b0000} +: 16];
        case (wb.LdType)
            3'd1:    ld_data = {24'h0, ld_byte};
            3'd2:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd3:    ld_data = {16'h0, ld_half};
            3'd4:    ld_data = {{16{ld_half[15]}}, ld_half};
            default: ld_data = wb.DR;
        endcase
    end

    // Writeback source mux and effective write enable.
    always_comb begin
        case (wb.WbSel)
            3'd0:    wb_data = wb.Y;
            3'd1:    wb_data = ld_data;
            3'd2:    wb_data = wb.PC + 32'd8;
            3'd3:    wb_data = wb.HILO;
            3'd4:    wb_data = {31'h0, wb.ACmpB == 2'b01};
            default: wb_data = 32'h0;
        endcase
        wb_we = wb.Valid && (wb.WbAddr != 5'd0);
    end

    // Next-state for GPRs, retire counter and last PC.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            gpr_d[i] = (wb_we && (wb.WbAddr == 5'(i))) ? wb_data : gpr_q[i];
        end
        retire_cnt_d = wb.Valid ? retire_cnt_q + 32'd1 : retire_cnt_q;
        last_pc_d    = wb.Valid ? wb.PC : last_pc_q;
    end

    // State registers; reset clears everything, dropping any in-flight write.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 1; i < 32; i++) begin
                gpr_q[i] <= 32'h0;
            end
            retire_cnt_q <= 32'h0;
            last_pc_q    <= 32'h0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            retire_cnt_q <= retire_cnt_d;
            last_pc_q    <= last_pc_d;
        end
    end

    // Read port 1: GPR0 is zero, a same-cycle write to the index bypasses.
    always_comb begin
        if (wb.RAddr1 == 5'd0)
            wb.RData1 = 32'h0;
        else if (wb_we && (wb.RAddr1 == wb.WbAddr))
            wb.RData1 = wb_data;
        else
            wb.RData1 = gpr_q[wb.RAddr1];
    end

    // Read port 2: identical behaviour to port 1.
    always_comb begin
        if (wb.RAddr2 == 5'd0)
            wb.RData2 = 32'h0;
        else if (wb_we && (wb.RAddr2 == wb.WbAddr))
            wb.RData2 = wb_data;
        else
            wb.RData2 = gpr_q[wb.RAddr2];
    end

    assign wb.WbData    = wb_data;
    assign wb.WbWe      = wb_we;
    assign wb.RetireCnt = retire_cnt_q;
    assign wb.LastPC    = last_pc_q;

endmodule

// File: tb/tb_w_writeback.sv
// Bench for w_writeback: directed vectors, a behavioural architectural
// model of the register file and retire state, and a negedge compare.
module tb_w_writeback;

  logic clk = 1'b0;
  logic rst;

  w_writeback_if bus ();

  w_writeback dut (
    .Clk (clk),
    .Rst (rst),
    .wb  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_cnt;
  logic [31:0] m_last;
  logic [31:0] c0;

  // Architectural load extension from byte/half offsets.
  function automatic logic [31:0] m_ext(input logic [2:0] lt, input logic [31:0] dr,
                                        input logic [31:0] y);
    logic [31:0] b;
    logic [31:0] h;
    b = (dr >> (8 * y[1:0])) & 32'hFF;
    h = (dr >> (16 * y[1])) & 32'hFFFF;
    case (lt)
      3'd1:    return b;
      3'd2:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      default: return dr;
    endcase
  endfunction

  function automatic logic [31:0] m_wbdata();
    case (bus.WbSel)
      3'd0:    return bus.Y;
      3'd1:    return m_ext(bus.LdType, bus.DR, bus.Y);
      3'd2:    return bus.PC + 32'd8;
      3'd3:    return bus.HILO;
      3'd4:    return (bus.ACmpB == 2'b01) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_we();
    return bus.Valid && (bus.WbAddr != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && (a == bus.WbAddr)) return m_wbdata();
    return m_gpr[a];
  endfunction

  // Model state update on the architectural clock/reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_cnt  = 32'd0;
      m_last = 32'd0;
    end else begin
      if (m_we()) m_gpr[bus.WbAddr] = m_wbdata();
      if (bus.Valid) begin
        m_cnt  = m_cnt + 32'd1;
        m_last = bus.PC;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("wbdata",     bus.WbData,            m_wbdata());
    check("wbwe",       {31'd0, bus.WbWe},     {31'd0, m_we()});
    check("rdata1",     bus.RData1,            m_read(bus.RAddr1));
    check("rdata2",     bus.RData2,            m_read(bus.RAddr2));
    check("retire_cnt", bus.RetireCnt,         m_cnt);
    check("last_pc",    bus.LastPC,            m_last);
  endtask

  // Compare process: outputs settled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [2:0] sel, input logic [4:0] addr,
                        input logic [2:0] lt, input logic [31:0] pc, input logic [31:0] dr,
                        input logic [31:0] y, input logic [31:0] hilo, input logic [1:0] acmp,
                        input logic [4:0] ra1, input logic [4:0] ra2);
    bus.Valid  = v;
    bus.WbSel  = sel;
    bus.WbAddr = addr;
    bus.LdType = lt;
    bus.PC     = pc;
    bus.DR     = dr;
    bus.Y      = y;
    bus.HILO   = hilo;
    bus.ACmpB  = acmp;
    bus.RAddr1 = ra1;
    bus.RAddr2 = ra2;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Drive a combinational case, check WbData against a literal, then clock it.
  task automatic lit_wb(input string name, input logic v, input logic [2:0] sel,
                        input logic [4:0] addr, input logic [2:0] lt, input logic [31:0] pc,
                        input logic [31:0] dr, input logic [31:0] y, input logic [31:0] hilo,
                        input logic [1:0] acmp, input logic [31:0] exp);
    set_in(v, sel, addr, lt, pc, dr, y, hilo, acmp, addr, 5'd0);
    mid();
    check(name, bus.WbData, exp);
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    #1;
    chk_en = 1'b1;

    // In reset: combinational path still live, state reads zero.
    set_in(1'b1, 3'd0, 5'd7, 3'd0, 32'h200, 32'd0, 32'hCAFE_0001, 32'd0, 2'b00, 5'd7, 5'd3);
    mid();
    check("rst_bypass", bus.RData1,    32'hCAFE_0001);
    check("rst_gpr",    bus.RData2,    32'h0);
    check("rst_cnt",    bus.RetireCnt, 32'h0);
    check("rst_lastpc", bus.LastPC,    32'h0);
    cyc();
    check("rst_no_cnt", bus.RetireCnt, 32'h0);
    set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd7, 5'd0);
    #2 rst = 1'b1;
    cyc();
    check("rst_no_write", bus.RData1, 32'h0);

    // Bypass then stored read of r5.
    set_in(1'b1, 3'd0, 5'd5, 3'd0, 32'h100, 32'd0, 32'h1234_5678, 32'd0, 2'b00, 5'd5, 5'd5);
    mid();
    check("bypass_r1", bus.RData1, 32'h1234_5678);
    cyc();
    set_in(1'b0, 3'd0, 5'd5, 3'd0, 32'h104, 32'd0, 32'hFFFF_FFFF, 32'd0, 2'b00, 5'd5, 5'd0);
    mid();
    check("stored_r1", bus.RData1, 32'h1234_5678);
    check("cnt_one",   bus.RetireCnt, 32'd1);
    check("last_100",  bus.LastPC, 32'h100);
    cyc();

    // Fill r9..r16 with distinct values; port 2 reads the previous write.
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 3'd0, 5'(i + 8), 3'd0, 32'h400 + 32'(4 * i), 32'd0,
             32'h1111_1111 * 32'(i), 32'd0, 2'b00, 5'(i + 8), 5'(i + 7));
      cyc();
    end
    // Valid=0 with a nonzero address must not write r9.
    set_in(1'b0, 3'd0, 5'd9, 3'd0, 32'h500, 32'd0, 32'hFFFF_0000, 32'd0, 2'b00, 5'd9, 5'd9);
    cyc();
    mid();
    check("nowrite_r9", bus.RData1, 32'h1111_1111);
    cyc();

    // Load extension cases, each written to r20.
    lit_wb("ld_lb_y3",  1'b1, 3'd1, 5'd20, 3'd2, 32'h600, 32'h80FF_7F01, 32'h3, 32'd0, 2'b00, 32'hFFFF_FF80);
    lit_wb("ld_lbu_y3", 1'b1, 3'd1, 5'd20, 3'd1, 32'h604, 32'h80FF_7F01, 32'h3, 32'd0, 2'b00, 32'h0000_0080);
    lit_wb("ld_lh_y0",  1'b1, 3'd1, 5'd20, 3'd4, 32'h608, 32'h80FF_7F01, 32'h0, 32'd0, 2'b00, 32'h0000_7F01);
    lit_wb("ld_lh_y2",  1'b1, 3'd1, 5'd20, 3'd4, 32'h60C, 32'h80FF_7F01, 32'h2, 32'd0, 2'b00, 32'hFFFF_80FF);
    lit_wb("ld_lhu_y2", 1'b1, 3'd1, 5'd20, 3'd3, 32'h610, 32'h80FF_7F01, 32'h2, 32'd0, 2'b00, 32'h0000_80FF);
    lit_wb("ld_lb_y1",  1'b1, 3'd1, 5'd20, 3'd2, 32'h614, 32'h80FF_7F01, 32'h1, 32'd0, 2'b00, 32'h0000_007F);
    lit_wb("ld_lbu_y2", 1'b1, 3'd1, 5'd20, 3'd1, 32'h618, 32'h80FF_7F01, 32'h2, 32'd0, 2'b00, 32'h0000_00FF);
    lit_wb("ld_word",   1'b1, 3'd1, 5'd20, 3'd0, 32'h61C, 32'h80FF_7F01, 32'h1, 32'd0, 2'b00, 32'h80FF_7F01);
    lit_wb("ld_type7",  1'b1, 3'd1, 5'd21, 3'd7, 32'h620, 32'h80FF_7F01, 32'h0, 32'd0, 2'b00, 32'h80FF_7F01);

    // Retire to r0: no write, but counter and LastPC advance.
    c0 = m_cnt;
    set_in(1'b1, 3'd2, 5'd0, 3'd0, 32'h0000_3000, 32'd0, 32'd0, 32'd0, 2'b00, 5'd0, 5'd0);
    mid();
    check("pc8_r0",   bus.WbData, 32'h0000_3008);
    check("we_r0",    {31'd0, bus.WbWe}, 32'd0);
    check("read_r0",  bus.RData1, 32'd0);
    cyc();
    set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd0, 5'd20);
    check("cnt_r0",   bus.RetireCnt, c0 + 32'd1);
    check("last_3000", bus.LastPC,   32'h0000_3000);
    cyc();

    // Other writeback sources.
    lit_wb("slt_lt",  1'b0, 3'd4, 5'd22, 3'd0, 32'd0, 32'd0, 32'hFFFF, 32'd0, 2'b01, 32'd1);
    lit_wb("slt_gt",  1'b1, 3'd4, 5'd22, 3'd0, 32'h700, 32'd0, 32'hFFFF, 32'd0, 2'b10, 32'd0);
    lit_wb("slt_eq",  1'b0, 3'd4, 5'd22, 3'd0, 32'd0, 32'd0, 32'hFFFF, 32'd0, 2'b00, 32'd0);
    lit_wb("hilo",    1'b1, 3'd3, 5'd30, 3'd0, 32'h704, 32'd0, 32'h1, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);
    lit_wb("pc8_wrap", 1'b1, 3'd2, 5'd31, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'h1, 32'd0, 2'b00, 32'h0000_0004);
    lit_wb("sel5",    1'b1, 3'd5, 5'd23, 3'd0, 32'h708, 32'h5, 32'h5, 32'h5, 2'b01, 32'd0);
    lit_wb("sel7",    1'b0, 3'd7, 5'd23, 3'd0, 32'h70C, 32'h5, 32'h5, 32'h5, 2'b01, 32'd0);

    // Sweep all registers, same index on both ports.
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'(a), 5'(a));
      cyc();
    end

    // Asynchronous reset mid-cycle during a write.
    set_in(1'b1, 3'd0, 5'd12, 3'd0, 32'h800, 32'd0, 32'h0000_ABCD, 32'd0, 2'b00, 5'd9, 5'd30);
    #2 rst = 1'b0;
    #1;
    check("arst_r9",     bus.RData1,    32'd0);
    check("arst_r30",    bus.RData2,    32'd0);
    check("arst_cnt",    bus.RetireCnt, 32'd0);
    check("arst_last",   bus.LastPC,    32'd0);
    check("arst_wbdata", bus.WbData,    32'h0000_ABCD);
    @(posedge clk);
    #2 rst = 1'b1;
    set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd12, 5'd9);
    mid();
    check("arst_dropped", bus.RData1, 32'd0);
    cyc();

    // Counter wrap: preload near the top, then retire twice.
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.retire_cnt_q;
    set_in(1'b1, 3'd0, 5'd1, 3'd0, 32'h900, 32'd0, 32'h77, 32'd0, 2'b00, 5'd1, 5'd0);
    cyc();
    check("cnt_ffff", bus.RetireCnt, 32'hFFFF_FFFF);
    set_in(1'b1, 3'd0, 5'd2, 3'd0, 32'h904, 32'd0, 32'h88, 32'd0, 2'b00, 5'd1, 5'd2);
    cyc();
    check("cnt_wrap", bus.RetireCnt, 32'h0000_0000);
    check("last_904", bus.LastPC,    32'h0000_0904);
    set_in(1'b0, 3'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 5'd1, 5'd2);
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
